dram_cache: RTL and testbench
=============================

Name: dram_cache

Overview:
- Direct-mapped, write-back, one-word-per-line cache between the core FSM and the DRAM bridge.
- Drives the bridge's C_* request interface: one C_in_valid pulse per transaction, then waits for C_out_valid.
- Hits complete without any DRAM traffic. Misses write back a dirty victim, then fill the line (reads only).

Parameters:
- LINES, 8, number of cache lines; power of two, 2..64; IDX_W = log2(LINES).
- ADDR_W, 8, word address width, matching the bridge C_addr.
- DATA_W, 32, word width, matching C_data_w / C_data_r.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  core request strobe
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid & req_ready
- req_r_wb  in  1  1 = read, 0 = write (same encoding as the bridge)
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  read data, valid with resp_valid; 0 otherwise
- C_in_valid  out  1  bridge request pulse
- C_r_wb  out  1  bridge direction
- C_addr  out  ADDR_W  bridge word address
- C_data_w  out  DATA_W  bridge write data
- C_out_valid  in  1  bridge completion
- C_data_r  in  DATA_W  bridge read data

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Address split: index = addr[IDX_W-1:0]; tag = addr[ADDR_W-1:IDX_W].
- Per-line state: valid, dirty, tag, data.
- Reset (sampled at posedge clk while rst=1):
  - All valid and dirty bits clear; dirty data is discarded.
  - FSM goes to IDLE.
  - All outputs are 0, except req_ready, which is 1 after reset releases.
  - Reset mid-transaction abandons it. The bridge must be reset in the same cycle.
- FSM states: IDLE, CHECK, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE.
- IDLE:
  - On acceptance, register r_wb, addr and wdata, then go to CHECK.
  - req_valid outside IDLE is ignored; no queueing.
- CHECK (hit = valid & tag match):
  - Read hit: go to DONE with the line data.
  - Write hit: write data, set dirty, go to DONE.
  - Miss with a valid, dirty victim: go to WB_REQ.
  - Read miss with a clean or invalid victim: go to FILL_REQ.
  - Write miss with a clean or invalid victim: install tag and data, set valid and dirty, go to DONE. Write-allocate needs no fetch because the line is one word.
- WB_REQ:
  - Assert C_in_valid for exactly one cycle with C_r_wb=0, C_addr={victim tag, index}, C_data_w=victim data.
  - Go to WB_WAIT.
- WB_WAIT:
  - On C_out_valid, clear dirty.
  - Then a read goes to FILL_REQ; a write installs as in CHECK and goes to DONE.
- FILL_REQ: assert C_in_valid for one cycle with C_r_wb=1, C_addr=request addr, C_data_w=0; go to FILL_WAIT.
- FILL_WAIT: on C_out_valid, install C_data_r (valid=1, dirty=0) and go to DONE.
- DONE: resp_valid=1 for one cycle, resp_rdata = read data (0 for writes); go to IDLE.
- All C_* and resp_* outputs are registered. C_addr, C_r_wb and C_data_w are 0 whenever C_in_valid=0.
- Latency, with acceptance at cycle T:
  - Any hit, or a clean write miss: resp_valid at T+2.
  - Misses: resp_valid at T+2 plus the bridge round trips.
- Only one bridge transaction is ever outstanding. C_out_valid outside WB_WAIT/FILL_WAIT is ignored.
- Back-to-back: the next request can be accepted the cycle after DONE.

Optional Feature:
- Macro: DRAM_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[15:0], miss_cnt[15:0], wb_cnt[15:0], all reset to 0 and saturating at 16'hFFFF.
  - hit_cnt / miss_cnt increment once per request in CHECK.
  - wb_cnt increments on each write-back C_out_valid.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package usertype gains:
  - typedef enum state_c {IDLE, CHECK, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE}.
  - Address and data word typedefs.
  - A line struct {valid, dirty, tag, data}.
- One sub-module: dram_cache_array, the line storage with one combinational read port and one synchronous write port. The FSM stays in dram_cache.

Test Plan:
- Read 8'h13 after reset, bridge returns 32'hDEAD_BEEF → one C_in_valid (r_wb=1, addr 8'h13). resp_rdata=32'hDEAD_BEEF. Re-read of 8'h13 gives resp_valid 2 cycles after acceptance with no C_in_valid.
- Write 8'h05=32'h1234_5678, then read 8'h05 → no bridge traffic; resp_rdata=32'h1234_5678.
- Write 8'h05=32'hA, then read 8'h0D (LINES=8, same index) → write-back pulse (r_wb=0, addr 8'h05, data 32'hA), then fill pulse (r_wb=1, addr 8'h0D), in that order.
- Bridge completion delayed 20 cycles → req_ready stays 0, no second C_in_valid, and a req_valid during the wait is ignored.
- rst asserted during FILL_WAIT → next cycle all outputs are 0, req_ready=1 after release, and a re-read of the same address misses.
- With DRAM_CACHE_STATS_EN: 3 hits, 2 misses, 1 write-back → hit_cnt=3, miss_cnt=2, wb_cnt=1.

Source files
------------

// File: rtl/dram_cache_pkg.sv
// ============================================================================
// Module      : dram_cache_pkg
// Description : Shared types for the direct-mapped write-back DRAM cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_cache_pkg;

    localparam int c_ADDR_W = 8;
    localparam int c_DATA_W = 32;

    typedef logic [c_ADDR_W-1:0] addr_t;
    typedef logic [c_DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        WB_REQ    = 3'd2,
        WB_WAIT   = 3'd3,
        FILL_REQ  = 3'd4,
        FILL_WAIT = 3'd5,
        DONE      = 3'd6
    } state_c;

    // Tag is held zero-extended in a full address word so the line type
    // does not depend on the number of index bits.
    typedef struct packed {
        logic  valid;
        logic  dirty;
        addr_t tag;
        word_t data;
    } line_t;

endpackage

`default_nettype wire

// File: rtl/dram_cache_array.sv
// ============================================================================
// Module      : dram_cache_array
// Description : Cache line storage, one combinational read port and one
//               synchronous write port; reset clears every line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_cache_array
    import dram_cache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output line_t            o_rd_line,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  line_t            i_wr_line
);

    line_t r_mem [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_line;
        end
    end

    assign o_rd_line = r_mem[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/dram_cache.sv
// ============================================================================
// Module      : dram_cache
// Description : Direct-mapped, write-back, one-word-per-line cache driving the
//               DRAM bridge request interface. Define DRAM_CACHE_STATS_EN to
//               add saturating hit/miss/write-back counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_cache
    import dram_cache_pkg::*;
#(
    parameter int LINES  = 8,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_r_wb,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              C_in_valid,
    output logic              C_r_wb,
    output logic [ADDR_W-1:0] C_addr,
    output logic [DATA_W-1:0] C_data_w,
    input  logic              C_out_valid,
    input  logic [DATA_W-1:0] C_data_r
`ifdef DRAM_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       wb_cnt
`endif
);

    localparam int IDX_W = $clog2(LINES);

    state_c            r_state;
    logic              r_r_wb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_c_in_valid;
    logic              r_c_r_wb;
    logic [ADDR_W-1:0] r_c_addr;
    logic [DATA_W-1:0] r_c_data_w;

    logic [IDX_W-1:0]  w_idx;
    addr_t             w_req_tag;
    line_t             w_line;
    logic              w_hit;
    logic              w_dirty_victim;
    logic              w_we;
    line_t             w_wr_line;

    assign w_idx          = r_addr[IDX_W-1:0];
    assign w_req_tag      = addr_t'(r_addr >> IDX_W);
    assign w_hit          = w_line.valid && (w_line.tag == w_req_tag);
    assign w_dirty_victim = w_line.valid && w_line.dirty;

    dram_cache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_rd_idx  (w_idx),
        .o_rd_line (w_line),
        .i_we      (w_we),
        .i_wr_idx  (w_idx),
        .i_wr_line (w_wr_line)
    );

    // Line updates land on the same edge as the state transition that
    // completes them, so the next request always sees the new contents.
    always_comb begin
        w_we      = 1'b0;
        w_wr_line = '0;
        case (r_state)
            CHECK: begin
                if (!r_r_wb && (w_hit || !w_dirty_victim)) begin
                    w_we      = 1'b1;
                    w_wr_line = '{valid: 1'b1, dirty: 1'b1, tag: w_req_tag,
                                  data: word_t'(r_wdata)};
                end
            end
            WB_WAIT: begin
                if (C_out_valid) begin
                    w_we = 1'b1;
                    if (r_r_wb) begin
                        w_wr_line       = w_line;
                        w_wr_line.dirty = 1'b0;
                    end else begin
                        w_wr_line = '{valid: 1'b1, dirty: 1'b1, tag: w_req_tag,
                                      data: word_t'(r_wdata)};
                    end
                end
            end
            FILL_WAIT: begin
                if (C_out_valid) begin
                    w_we      = 1'b1;
                    w_wr_line = '{valid: 1'b1, dirty: 1'b0, tag: w_req_tag,
                                  data: word_t'(C_data_r)};
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_r_wb       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_c_in_valid <= 1'b0;
            r_c_r_wb     <= 1'b0;
            r_c_addr     <= '0;
            r_c_data_w   <= '0;
        end else begin
            // Every output is a single-cycle pulse unless re-armed below.
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_c_in_valid <= 1'b0;
            r_c_r_wb     <= 1'b0;
            r_c_addr     <= '0;
            r_c_data_w   <= '0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_r_wb  <= req_r_wb;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_r_wb ? DATA_W'(w_line.data) : '0;
                        r_state      <= DONE;
                    end else if (w_dirty_victim) begin
                        r_c_in_valid <= 1'b1;
                        r_c_r_wb     <= 1'b0;
                        r_c_addr     <= ADDR_W'((w_line.tag << IDX_W) | addr_t'(w_idx));
                        r_c_data_w   <= DATA_W'(w_line.data);
                        r_state      <= WB_REQ;
                    end else if (r_r_wb) begin
                        r_c_in_valid <= 1'b1;
                        r_c_r_wb     <= 1'b1;
                        r_c_addr     <= r_addr;
                        r_state      <= FILL_REQ;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                WB_REQ: begin
                    r_state <= WB_WAIT;
                end
                WB_WAIT: begin
                    if (C_out_valid) begin
                        if (r_r_wb) begin
                            r_c_in_valid <= 1'b1;
                            r_c_r_wb     <= 1'b1;
                            r_c_addr     <= r_addr;
                            r_state      <= FILL_REQ;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                end
                FILL_REQ: begin
                    r_state <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (C_out_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= C_data_r;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign C_in_valid = r_c_in_valid;
    assign C_r_wb     = r_c_r_wb;
    assign C_addr     = r_c_addr;
    assign C_data_w   = r_c_data_w;

`ifdef DRAM_CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic [15:0] r_wb_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (r_state == CHECK) begin
                if (w_hit) begin
                    if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
                end else begin
                    if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
                end
            end
            if ((r_state == WB_WAIT) && C_out_valid && (r_wb_cnt != 16'hFFFF)) begin
                r_wb_cnt <= r_wb_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
    assign wb_cnt   = r_wb_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dram_cache.sv
// ============================================================================
// Module      : tb_dram_cache
// Description : Self-checking bench for dram_cache: bridge responder, a
//               memory-view reference model, directed and random requests.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dram_cache;

    typedef struct packed {
        logic        r_wb;
        logic [7:0]  addr;
        logic [31:0] data;
    } tx_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_r_wb;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        C_in_valid;
    logic        C_r_wb;
    logic [7:0]  C_addr;
    logic [31:0] C_data_w;
    logic        C_out_valid;
    logic [31:0] C_data_r;
`ifdef DRAM_CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] wb_cnt;
`endif

    int compared = 0;
    int mism     = 0;

    // Bridge side: its memory, log of requests, protocol violations.
    logic [31:0] dram [256];
    tx_t         txq[$];
    int          bridge_delay = 1;
    int          proto_err    = 0;

    // Reference: what the core should observe, and which address each line holds.
    logic [31:0] ref_mem [256];
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [7:0]  m_addr  [8];

    always #5 clk = ~clk;

    dram_cache #(
        .LINES  (8),
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_r_wb    (req_r_wb),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .C_in_valid  (C_in_valid),
        .C_r_wb      (C_r_wb),
        .C_addr      (C_addr),
        .C_data_w    (C_data_w),
        .C_out_valid (C_out_valid),
        .C_data_r    (C_data_r)
`ifdef DRAM_CACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt),
        .wb_cnt      (wb_cnt)
`endif
    );

    initial begin : bridge
        tx_t t;
        bit  aborted;
        for (int i = 0; i < 256; i++) dram[i] = $urandom;
        dram[8'h13] = 32'hDEAD_BEEF;
        C_out_valid = 1'b0;
        C_data_r    = '0;
        forever begin
            @(negedge clk);
            C_out_valid = 1'b0;
            C_data_r    = '0;
            if (C_in_valid && !rst) begin
                t = '{C_r_wb, C_addr, C_data_w};
                txq.push_back(t);
                aborted = 1'b0;
                for (int k = 0; k < bridge_delay; k++) begin
                    @(negedge clk);
                    if (C_in_valid || C_r_wb || C_addr != 0 || C_data_w != 0) proto_err++;
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    if (t.r_wb) C_data_r = dram[t.addr];
                    else        dram[t.addr] = t.data;
                    C_out_valid = 1'b1;
                end
            end else if (C_r_wb || C_addr != 0 || C_data_w != 0) begin
                proto_err++;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_addr[i]  = '0;
        end
        // Dirty lines are discarded on reset, so the core's view reverts to DRAM.
        ref_mem = dram;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_clear();
    endtask

    task automatic do_req(input logic rwb, input logic [7:0] a, input logic [31:0] wd,
                          input bit poke, output logic [31:0] rd, output int lat);
        int guard;
        bit ready_leak;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_r_wb  = rwb;
        req_addr  = a;
        req_wdata = wd;
        lat        = 0;
        rd         = '0;
        ready_leak = 1'b0;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_r_wb  = 1'b0;
                req_addr  = '0;
                req_wdata = '0;
            end
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                break;
            end
            if (req_ready) ready_leak = 1'b1;
            if (poke) begin
                req_valid = (k >= 3 && k <= 6);
                req_r_wb  = 1'b1;
                req_addr  = 8'hF0;
            end
        end
        req_valid = 1'b0;
        req_addr  = '0;
        req_r_wb  = 1'b0;
        chk("resp_seen", lat != 0, 1);
        chk("ready_low_while_busy", ready_leak, 0);
    endtask

    task automatic run_req(input logic rwb, input logic [7:0] a, input logic [31:0] wd,
                           input bit poke);
        tx_t         exp_q[$];
        int          idx;
        int          base;
        bit          hit;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int          lat;
        idx = a % 8;
        hit = m_valid[idx] && (m_addr[idx] == a);
        if (!hit && m_valid[idx] && m_dirty[idx])
            exp_q.push_back('{1'b0, m_addr[idx], ref_mem[m_addr[idx]]});
        if (!hit && rwb)
            exp_q.push_back('{1'b1, a, 32'h0});
        exp_rd = rwb ? ref_mem[a] : 32'h0;
        base   = txq.size();
        do_req(rwb, a, wd, poke, rd, lat);
        chk("tx_count", txq.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < txq.size()) begin
                chk("tx_r_wb", txq[base+i].r_wb, exp_q[i].r_wb);
                chk("tx_addr", txq[base+i].addr, exp_q[i].addr);
                chk("tx_data", txq[base+i].data, exp_q[i].data);
            end
        end
        chk("resp_rdata", rd, exp_rd);
        if (exp_q.size() == 0) chk("no_traffic_latency", lat, 2);
        if (!rwb) ref_mem[a] = wd;
        if (!hit) begin
            m_valid[idx] = 1'b1;
            m_addr[idx]  = a;
            m_dirty[idx] = !rwb;
        end else if (!rwb) begin
            m_dirty[idx] = 1'b1;
        end
    endtask

    initial begin : stimulus
        int guard;
        int base;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_r_wb  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_clear();

        chk("reset_req_ready", req_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_rdata", resp_rdata, 0);
        chk("reset_c_in_valid", C_in_valid, 0);
        chk("reset_c_addr", C_addr, 0);
        chk("reset_c_data_w", C_data_w, 0);

        // Cold read then re-read hit
        run_req(1'b1, 8'h13, 32'h0, 1'b0);
        run_req(1'b1, 8'h13, 32'h0, 1'b0);
        // Write-allocate then read back, no bridge traffic
        run_req(1'b0, 8'h05, 32'h1234_5678, 1'b0);
        run_req(1'b1, 8'h05, 32'h0, 1'b0);
        // Dirty conflict: write-back of 05 must precede the fill of 0D
        run_req(1'b0, 8'h05, 32'h0000_000A, 1'b0);
        run_req(1'b1, 8'h0D, 32'h0, 1'b0);

        // Slow bridge with a stray request while busy
        bridge_delay = 20;
        run_req(1'b1, 8'h2A, 32'h0, 1'b1);
        bridge_delay = 30;

        // Reset while waiting for a fill
        @(negedge clk);
        chk("ready_before_abort_req", req_ready, 1);
        base      = txq.size();
        req_valid = 1'b1;
        req_r_wb  = 1'b1;
        req_addr  = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        req_r_wb  = 1'b0;
        req_addr  = '0;
        guard = 0;
        while (!(txq.size() > base && txq[txq.size()-1].r_wb) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("fill_issued_before_abort", guard < 300, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_resp_rdata", resp_rdata, 0);
        chk("abort_c_in_valid", C_in_valid, 0);
        chk("abort_c_r_wb", C_r_wb, 0);
        chk("abort_c_addr", C_addr, 0);
        chk("abort_c_data_w", C_data_w, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after_release", req_ready, 1);
        model_clear();
        bridge_delay = 1;
        run_req(1'b1, 8'h77, 32'h0, 1'b0);

        // Random traffic concentrated on a few lines to force conflicts
        for (int n = 0; n < 150; n++) begin
            bridge_delay = $urandom_range(1, 4);
            run_req(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 23)),
                    $urandom, 1'b0);
        end
        bridge_delay = 1;

`ifdef DRAM_CACHE_STATS_EN
        do_reset();
        chk("stats_reset_hit", hit_cnt, 0);
        run_req(1'b0, 8'h01, 32'h0BAD_F00D, 1'b0);
        run_req(1'b1, 8'h01, 32'h0, 1'b0);
        run_req(1'b1, 8'h01, 32'h0, 1'b0);
        run_req(1'b1, 8'h09, 32'h0, 1'b0);
        run_req(1'b1, 8'h09, 32'h0, 1'b0);
        @(negedge clk);
        chk("stats_hit_cnt", hit_cnt, 3);
        chk("stats_miss_cnt", miss_cnt, 2);
        chk("stats_wb_cnt", wb_cnt, 1);
`endif

        repeat (2) @(negedge clk);
        chk("bridge_protocol_errors", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

`default_nettype wire
